// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder
// Purpose  : Parametrised pipelined add/subtract unit. The WIDTH-bit
//            operation is split into STAGES ripple-carry chunks of
//            WIDTH/STAGES bits. Each chunk is one register stage, and the
//            carry passes from stage to stage. The unit provides
//            carry/overflow/zero flags and valid/ready flow control.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_adder #(
    parameter int WIDTH  = 32,  // must be a multiple of STAGES
    parameter int STAGES = 4    // 1..WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int c_cw = WIDTH / STAGES;

    logic w_advance;
    logic r_overflow;
    logic r_zero;

    // The whole pipe moves together. The pipe only stops when a finished
    // result is waiting on the consumer, so bubbles are held as well.
    assign w_advance = ~out_valid | out_ready;
    assign in_ready  = w_advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits that are still to be added when this stage is entered.
        localparam int c_in_w  = WIDTH - k * c_cw;
        // Result bits that are known once this stage has completed.
        localparam int c_res_w = (k + 1) * c_cw;

        logic [c_in_w-1:0]  w_ua;
        logic [c_in_w-1:0]  w_ub;
        logic               w_cin;
        logic               w_vin;
        logic [c_cw:0]      w_chunk;
        logic [c_res_w-1:0] w_res;
        logic [c_res_w-1:0] r_res;
        logic               r_c;
        logic               r_v;

        if (k == 0) begin : g_entry
            // Subtract is computed as a + ~b + !cin.
            assign w_ua  = a;
            assign w_ub  = sub ? ~b : b;
            assign w_cin = sub ^ cin;
            assign w_vin = in_valid;
            assign w_res = w_chunk[c_cw-1:0];
        end else begin : g_link
            assign w_ua  = g_stage[k-1].g_mid.r_ua;
            assign w_ub  = g_stage[k-1].g_mid.r_ub;
            assign w_cin = g_stage[k-1].r_c;
            assign w_vin = g_stage[k-1].r_v;
            assign w_res = {w_chunk[c_cw-1:0], g_stage[k-1].r_res};
        end

        // The ripple chunk for this stage. The top bit of w_chunk is the
        // carry out of the chunk.
        assign w_chunk = {1'b0, w_ua[c_cw-1:0]} + {1'b0, w_ub[c_cw-1:0]}
                       + {{c_cw{1'b0}}, w_cin};

        if (k < STAGES - 1) begin : g_mid
            logic [c_in_w-c_cw-1:0] r_ua;
            logic [c_in_w-c_cw-1:0] r_ub;

            // Intermediate stage: store partial result, carry and operand bits not yet added.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_v   <= 1'b0;
                    r_c   <= 1'b0;
                    r_res <= '0;
                    r_ua  <= '0;
                    r_ub  <= '0;
                end else if (w_advance) begin
                    r_v   <= w_vin;
                    r_c   <= w_chunk[c_cw];
                    r_res <= w_res;
                    r_ua  <= w_ua[c_in_w-1:c_cw];
                    r_ub  <= w_ub[c_in_w-1:c_cw];
                end
            end
        end else begin : g_last
            logic w_msb_cin;

            // Recover the carry into the MSB from the MSB sum bit. The MSB sum
            // bit is a ^ b ^ carry-in.
            assign w_msb_cin = w_ua[c_cw-1] ^ w_ub[c_cw-1] ^ w_chunk[c_cw-1];

            // Output stage: bubbles clear the valid bit but keep the last result and flags.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_v        <= 1'b0;
                    r_c        <= 1'b0;
                    r_res      <= '0;
                    r_overflow <= 1'b0;
                    r_zero     <= 1'b0;
                end else if (w_advance) begin
                    r_v <= w_vin;
                    if (w_vin) begin
                        r_res      <= w_res;
                        r_c        <= w_chunk[c_cw];
                        r_overflow <= w_msb_cin ^ w_chunk[c_cw];
                        r_zero     <= ~|w_res;
                    end
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_v;
    assign sum       = g_stage[STAGES-1].r_res;
    assign carry_out = g_stage[STAGES-1].r_c;
    assign overflow  = r_overflow;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_adder
// Purpose  : Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4),
//            with a scoreboard of reference results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ov;
        logic             z;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    bit   hold_valid = 1'b0;
    exp_t held;

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Reference: add computed at WIDTH+1 bits, subtract computed as a true
    // difference with borrow detection.
    function automatic exp_t model(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y,
                                   logic s, logic c);
        logic [WIDTH:0] t;
        exp_t e;
        if (!s) begin
            t    = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(c);
            e.s  = t[WIDTH-1:0];
            e.co = t[WIDTH];
            e.ov = (x[WIDTH-1] == y[WIDTH-1]) && (e.s[WIDTH-1] != x[WIDTH-1]);
        end else begin
            e.s  = x - y - WIDTH'(c);
            e.co = ({1'b0, x} >= ({1'b0, y} + (WIDTH+1)'(c)));
            e.ov = (x[WIDTH-1] != y[WIDTH-1]) && (e.s[WIDTH-1] != x[WIDTH-1]);
        end
        e.z = (e.s == '0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle. Inputs are driven at the falling edge and sampled 1 ns
    // later. The transfers seen here take effect at the next rising edge.
    task automatic step(input bit iv, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input bit isub, input bit icin, input bit ordy);
        exp_t e;
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        sub       = isub;
        cin       = icin;
        out_ready = ordy;
        #1;
        chk("in_ready_rule", in_ready, !out_valid || out_ready);
        if (hold_valid) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_sum", sum, held.s);
            chk("stall_flags", {carry_out, overflow, zero}, {held.co, held.ov, held.z});
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                e = sb.pop_front();
                n_out++;
                chk("sum", sum, e.s);
                chk("carry_out", carry_out, e.co);
                chk("overflow", overflow, e.ov);
                chk("zero", zero, e.z);
            end
        end
        hold_valid = out_valid && !out_ready;
        held       = '{s: sum, co: carry_out, ov: overflow, z: zero};
        if (in_valid && in_ready) sb.push_back(model(ia, ib, isub, icin));
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, '0, '0, 1'b0, 1'b0, ordy);
    endtask

    // Send one op into an empty pipe. The result must appear exactly STAGES
    // cycles later and must equal the given constants.
    task automatic single_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                             input bit isub, input bit icin,
                             input logic [WIDTH-1:0] xs, input bit xco, input bit xov);
        step(1'b1, ia, ib, isub, icin, 1'b1);
        for (int j = 1; j < STAGES; j++) begin
            idle(1'b1);
            chk("latency_early", out_valid, 0);
        end
        idle(1'b1);
        chk("latency_hit", out_valid, 1);
        chk("direct_sum", sum, xs);
        chk("direct_co", carry_out, xco);
        chk("direct_ov", overflow, xov);
        chk("direct_zero", zero, xs == '0);
    endtask

    initial begin
        int n0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_sum", sum, 0);
        chk("reset_flags", {carry_out, overflow, zero}, 3'b000);
        chk("reset_in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed: carry chain, signed overflow, borrow, and borrow-in.
        single_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        single_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        single_op(16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        single_op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        single_op(16'h000A, 16'h0003, 1'b1, 1'b1, 16'h0006, 1'b1, 1'b0);

        // Back-to-back: 20 ops with no stalls, one result per cycle from cycle 4.
        n0 = n_out;
        for (int i = 0; i < 24; i++) begin
            step(i < 20, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            chk("thru_valid", out_valid, i >= STAGES);
        end
        idle(1'b1);
        chk("thru_drained", out_valid, 0);
        chk("thru_count", n_out - n0, 20);

        // Backpressure: consumer stalls for 6 cycles while ops are still offered.
        n0 = n_out;
        for (int i = 0; i < 4; i++)
            step(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            chk("bp_in_ready", in_ready, 0);
        end
        for (int i = 0; i < 10; i++) idle(1'b1);
        chk("bp_count", n_out - n0, 4);
        chk("bp_queue_empty", sb.size(), 0);

        // Reset mid-stream: assert rst between edges while results are in flight.
        for (int i = 0; i < 5; i++)
            step(1'b1, 16'h1000 + 16'(i), 16'h0101, 1'b0, 1'b0, 1'b1);
        chk("pre_rst_valid", out_valid, 1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_sum", sum, 0);
        chk("async_rst_flags", {carry_out, overflow, zero}, 3'b000);
        sb.delete();
        hold_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idle(1'b1);
            chk("post_rst_quiet", out_valid, 0);
        end

        // Random ops with random consumer stalls, then a bounded drain.
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, WIDTH'($urandom), WIDTH'($urandom),
                 1'($urandom), 1'($urandom), $urandom_range(0, 9) < 7);
        for (int i = 0; i < 40 && sb.size() != 0; i++) idle(1'b1);
        chk("final_queue_empty", sb.size(), 0);
        idle(1'b1);
        chk("final_idle", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
